// File: rtl/fpu_result_uart_tx.sv
// Queues completed half-precision FPU results and returns each one to the host as two
// 8N1 UART frames, low byte first, using a bit period latched per result.
module fpu_result_uart_tx #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        result_valid,
    input  logic [15:0] result_data,
    input  logic [15:0] clks_per_bit,
    output logic        tx_serial,
    output logic        tx_busy,
    output logic        fifo_full,
    output logic        overflow,
    output logic        tx_done
);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    state_t             state_q, state_d;
    logic [15:0]        mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]     count_q, count_d;
    logic [15:0]        shift_q, shift_d;
    logic [15:0]        period_q, period_d;
    logic [15:0]        cnt_q, cnt_d;
    logic [2:0]         bit_idx_q, bit_idx_d;
    logic               byte_sel_q, byte_sel_d;
    logic               tx_serial_q, tx_serial_d;
    logic               tx_busy_q, tx_busy_d;
    logic               fifo_full_q, fifo_full_d;
    logic               overflow_q, overflow_d;
    logic               tx_done_q, tx_done_d;
    logic               full, pop, push, bit_end;
    logic [7:0]         cur_byte_d;

    // The FSM only pops from IDLE, so an entry pushed this cycle is never popped before the next.
    always_comb begin
        full       = (count_q == FULL_CNT);
        pop        = (state_q == IDLE) && (count_q != '0);
        push       = result_valid && (!full || pop);
        wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d    = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        overflow_d  = overflow_q | (result_valid & full & ~pop);
        fifo_full_d = (count_d == FULL_CNT);
    end

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        period_d   = period_q;
        cnt_d      = cnt_q;
        bit_idx_d  = bit_idx_q;
        byte_sel_d = byte_sel_q;
        tx_done_d  = 1'b0;
        bit_end    = (cnt_q == period_q - 16'd1);
        case (state_q)
            IDLE: begin
                if (pop) begin
                    shift_d    = mem_q[rd_ptr_q];
                    period_d   = (clks_per_bit == 16'd0) ? 16'd1 : clks_per_bit;
                    byte_sel_d = 1'b0;
                    cnt_d      = '0;
                    state_d    = START;
                end
            end
            START: begin
                if (bit_end) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = DATA;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (bit_idx_q == 3'd7) state_d = STOP;
                    else bit_idx_d = bit_idx_q + 3'd1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (!byte_sel_q) begin
                        byte_sel_d = 1'b1;
                        state_d    = START;
                    end else begin
                        tx_done_d = 1'b1;
                        state_d   = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Line level is computed from next-state so the registered output lines up with the state.
        cur_byte_d = byte_sel_d ? shift_d[15:8] : shift_d[7:0];
        case (state_d)
            START:   tx_serial_d = 1'b0;
            DATA:    tx_serial_d = cur_byte_d[bit_idx_d];
            default: tx_serial_d = 1'b1;
        endcase
        tx_busy_d = (state_d != IDLE) || (count_d != '0);
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= result_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            shift_q     <= '0;
            period_q    <= 16'd1;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            byte_sel_q  <= 1'b0;
            tx_serial_q <= 1'b1;
            tx_busy_q   <= 1'b0;
            fifo_full_q <= 1'b0;
            overflow_q  <= 1'b0;
            tx_done_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            shift_q     <= shift_d;
            period_q    <= period_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            byte_sel_q  <= byte_sel_d;
            tx_serial_q <= tx_serial_d;
            tx_busy_q   <= tx_busy_d;
            fifo_full_q <= fifo_full_d;
            overflow_q  <= overflow_d;
            tx_done_q   <= tx_done_d;
        end
    end

    assign tx_serial = tx_serial_q;
    assign tx_busy   = tx_busy_q;
    assign fifo_full = fifo_full_q;
    assign overflow  = overflow_q;
    assign tx_done   = tx_done_q;

endmodule

// File: tb/tb_fpu_result_uart_tx.sv
// Directed bench for fpu_result_uart_tx: a UART line monitor decodes every result and
// checks word value, framing and 20*P length against hand-written expectations.
module tb_fpu_result_uart_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        result_valid = 1'b0;
    logic [15:0] result_data = '0;
    logic [15:0] clks_per_bit = 16'd4;
    logic        tx_serial, tx_busy, fifo_full, overflow, tx_done;

    int checks = 0;
    int failures = 0;

    logic [15:0] exp_d [$];
    int          exp_p [$];

    fpu_result_uart_tx #(.DEPTH(4), .PTR_W(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .result_valid (result_valid),
        .result_data  (result_data),
        .clks_per_bit (clks_per_bit),
        .tx_serial    (tx_serial),
        .tx_busy      (tx_busy),
        .fifo_full    (fifo_full),
        .overflow     (overflow),
        .tx_done      (tx_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] v);
        result_valid = 1'b1;
        result_data  = v;
        step();
        result_valid = 1'b0;
    endtask

    task automatic expect_result(input logic [15:0] v, input int p);
        exp_d.push_back(v);
        exp_p.push_back(p);
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        while (tx_busy !== 1'b0 && n < limit) begin
            step();
            n++;
        end
        chk("idle_timeout", 32'(n < limit), 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    // Decodes one result per start edge, sampling mid-bit; aborts if reset hits mid-result.
    initial begin : uart_mon
        int p, idx, s, pos;
        logic [15:0] word;
        logic frame_ok, aborted, done_seen;
        forever begin
            step();
            if (!rst && tx_serial === 1'b0) begin
                if (exp_p.size() == 0) begin
                    chk("unexpected_frame", 32'd1, 32'd0);
                    p = 4;
                end else begin
                    p = exp_p.pop_front();
                end
                word = '0;
                frame_ok = 1'b1;
                aborted = 1'b0;
                done_seen = 1'b0;
                for (int c = 0; c <= 20 * p; c++) begin
                    if (c > 0) step();
                    if (rst) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (c == 20 * p) begin
                        done_seen = tx_done;
                    end else if (c % p == p / 2) begin
                        s = c / p;
                        pos = s % 10;
                        if (pos == 0) frame_ok = frame_ok & (tx_serial === 1'b0);
                        else if (pos == 9) frame_ok = frame_ok & (tx_serial === 1'b1);
                        else begin
                            idx = (s / 10) * 8 + pos - 1;
                            word[idx] = tx_serial;
                        end
                    end
                end
                if (!aborted) begin
                    chk("framing", 32'(frame_ok), 32'd1);
                    chk("tx_done_at_20P", 32'(done_seen), 32'd1);
                    if (exp_d.size() == 0) chk("unexpected_word", 32'(word), 32'hFFFF_FFFF);
                    else chk("rx_word", 32'(word), 32'(exp_d.pop_front()));
                end
            end
        end
    end

    initial begin : stim
        int lows;

        // Reset values
        step();
        chk("rst_tx_serial", 32'(tx_serial), 32'd1);
        chk("rst_tx_busy",   32'(tx_busy),   32'd0);
        chk("rst_fifo_full", 32'(fifo_full), 32'd0);
        chk("rst_overflow",  32'(overflow),  32'd0);
        chk("rst_tx_done",   32'(tx_done),   32'd0);
        rst = 1'b0;
        step();

        // Single result, P=4: start bit two cycles after push, 80-cycle result
        clks_per_bit = 16'd4;
        expect_result(16'h3C00, 4);
        push(16'h3C00);
        chk("n1_line_high", 32'(tx_serial), 32'd1);
        chk("n1_busy",      32'(tx_busy),   32'd1);
        step();
        chk("n2_start_bit", 32'(tx_serial), 32'd0);
        wait_idle(200);
        chk("done_with_busy", 32'(tx_done), 32'd1);
        step();
        step();
        chk("t1_all_rx", 32'(exp_d.size()), 32'd0);

        // Five consecutive pushes: first is popped before the fifth arrives
        for (int i = 1; i <= 5; i++) expect_result(16'(i), 4);
        for (int i = 1; i <= 5; i++) push(16'(i));
        chk("b5_full", 32'(fifo_full), 32'd1);
        chk("b5_no_ovf", 32'(overflow), 32'd0);
        wait_idle(1000);
        step();
        step();
        chk("b5_no_ovf_end", 32'(overflow), 32'd0);
        chk("b5_all_rx", 32'(exp_d.size()), 32'd0);

        // Six consecutive pushes: the last one lands on a full FIFO and is dropped
        for (int i = 1; i <= 5; i++) expect_result(16'h0010 + 16'(i), 4);
        for (int i = 1; i <= 6; i++) push(16'h0010 + 16'(i));
        chk("b6_full", 32'(fifo_full), 32'd1);
        chk("b6_ovf", 32'(overflow), 32'd1);
        wait_idle(1000);
        step();
        step();
        chk("b6_ovf_sticky", 32'(overflow), 32'd1);
        chk("b6_all_rx", 32'(exp_d.size()), 32'd0);
        do_reset();
        chk("ovf_cleared", 32'(overflow), 32'd0);

        // FIFO full with a push landing in the pop cycle
        expect_result(16'h00A0, 4);
        for (int i = 1; i <= 4; i++) expect_result(16'h00B0 + 16'(i), 4);
        expect_result(16'h00C5, 4);
        push(16'h00A0);
        for (int i = 1; i <= 4; i++) push(16'h00B0 + 16'(i));
        chk("fp_full", 32'(fifo_full), 32'd1);
        lows = 0;
        while (tx_done !== 1'b1 && lows < 200) begin
            step();
            lows++;
        end
        chk("fp_done_timeout", 32'(lows < 200), 32'd1);
        chk("fp_full_at_pop", 32'(fifo_full), 32'd1);
        push(16'h00C5);
        chk("fp_still_full", 32'(fifo_full), 32'd1);
        chk("fp_no_ovf", 32'(overflow), 32'd0);
        wait_idle(1000);
        step();
        step();
        chk("fp_all_rx", 32'(exp_d.size()), 32'd0);

        // clks_per_bit change mid-result applies to the next result only
        clks_per_bit = 16'd4;
        expect_result(16'h1357, 4);
        expect_result(16'h2468, 8);
        push(16'h1357);
        step();
        clks_per_bit = 16'd8;
        push(16'h2468);
        wait_idle(600);
        step();
        step();
        chk("pc_all_rx", 32'(exp_d.size()), 32'd0);

        // clks_per_bit = 0 behaves as one cycle per bit
        clks_per_bit = 16'd0;
        expect_result(16'hFFFF, 1);
        push(16'hFFFF);
        wait_idle(100);
        step();
        step();
        chk("p0_all_rx", 32'(exp_d.size()), 32'd0);

        // Reset during bit 0 of the low byte drops the frame and the queue
        clks_per_bit = 16'd4;
        expect_result(16'h5500, 4);
        push(16'h5500);
        push(16'h1234);
        push(16'h5678);
        step();
        step();
        step();
        chk("mr_data_bit0", 32'(tx_serial), 32'd0);
        rst = 1'b1;
        #1;
        chk("mr_async_line", 32'(tx_serial), 32'd1);
        chk("mr_async_busy", 32'(tx_busy),   32'd0);
        exp_d.delete();
        exp_p.delete();
        step();
        step();
        step();
        rst = 1'b0;
        step();
        chk("mr_busy_after", 32'(tx_busy), 32'd0);
        lows = 0;
        for (int i = 0; i < 60; i++) begin
            if (tx_serial !== 1'b1) lows++;
            step();
        end
        chk("mr_no_replay", 32'(lows), 32'd0);
        chk("mr_busy_end", 32'(tx_busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fpu_result_uart_tx.md
Name: fpu_result_uart_tx

Overview:
- Downstream stage of the FPU FSM top level. It consumes each completed 16-bit half-precision result and returns it to the host over the same serial link the program was loaded on.
- Completed results are queued in a small FIFO. Each result is then sent as two 8N1 UART frames, low byte first.
- Bit timing comes from a runtime clocks-per-bit input, mirroring the receive side (348 in the chip build).

Parameters:
- DEPTH, 4, FIFO entries (power of two, at least 2)
- PTR_W, 2, log2(DEPTH)

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-high
- result_valid  input  1  one-cycle pulse: result_data holds a completed FPU result
- result_data  input  16  half-precision result
- clks_per_bit  input  16  clk cycles per UART bit
- tx_serial  output  1  UART line, idles high
- tx_busy  output  1  high while a frame is in progress or the FIFO is non-empty
- fifo_full  output  1  FIFO holds DEPTH entries
- overflow  output  1  sticky: a result was dropped
- tx_done  output  1  one-cycle pulse after the stop bit of a result's high byte

Behaviour:
- Clock, reset and reset values:
  - Single clock domain.
  - rst is asynchronous and active-high.
  - While rst is high: tx_serial=1, tx_busy=0, fifo_full=0, overflow=0, tx_done=0. The FIFO is emptied, pointers are 0, and the FSM is in IDLE.
  - Reset asserted mid-frame aborts the frame immediately; the line returns high asynchronously.
- FIFO:
  - Registered storage with write pointer, read pointer and a count of PTR_W+1 bits. Pointers wrap modulo DEPTH.
  - Push when result_valid=1 and not full.
  - Push while full with no pop in the same cycle: data is discarded and overflow is set until reset.
  - Push while full in a cycle where a pop occurs: push is accepted and overflow is not set.
  - Push and pop in the same cycle leave the count unchanged.
  - No bypass: a pushed entry becomes poppable on the next cycle.
- FSM states:
  - IDLE: tx_serial=1. If the FIFO is non-empty, pop the head into a 16-bit shift holder, latch clks_per_bit into a bit-period register, clear byte_sel, and go to START.
  - START: tx_serial=0 for one bit period, then go to DATA with bit_idx=0.
  - DATA: tx_serial = current byte, bit bit_idx, LSB first. Each bit lasts one bit period. After bit 7, go to STOP.
  - STOP: tx_serial=1 for one bit period. Then:
    - If byte_sel=0: set byte_sel=1 and go to START to send the high byte.
    - Else: pulse tx_done and go to IDLE.
- Byte order: byte 0 = result_data[7:0], byte 1 = result_data[15:8].
- Bit period:
  - Bit-period counter counts 0..P-1, where P is the value latched at the start of the result.
  - P=0 is treated as 1.
  - Changes to clks_per_bit during a result take effect on the next result only.
- Latency:
  - Push in cycle N, pop in cycle N+1.
  - tx_serial goes low in cycle N+2 (START is entered on the pop edge).
  - One result occupies the line for exactly 20*P cycles.
  - Back-to-back results: the next start bit follows in the cycle after IDLE, giving one idle-high cycle between results.
- Status timing:
  - tx_busy = (state != IDLE) or (count != 0), registered.
  - fifo_full is registered and updates in the same cycle as count.

Test Plan:
- Reset, then one push of 0x3C00 with clks_per_bit=4 → start bit 2 cycles after push. Line carries 0x00 then 0x3C, LSB first, each frame 40 cycles. tx_done pulses at cycle 80 after the start bit. tx_busy falls with it.
- Push 5 results (0x0001..0x0005) in consecutive cycles with DEPTH=4, P=4 → the first is popped before the 5th arrives, so all 5 are sent in order and overflow stays 0. Repeat the push burst after the first pop with 6 results → overflow=1 and exactly one value is lost (the last pushed while full).
- FIFO full, with a push coinciding with the pop cycle → push accepted, overflow remains 0, count stays DEPTH.
- Change clks_per_bit from 4 to 8 mid-result → current result keeps 4-cycle bits; the next result uses 8-cycle bits (160 cycles).
- Assert rst during DATA of byte 0 → tx_serial=1 in the same cycle (async). After release, tx_busy=0 and the queued results are gone.
- clks_per_bit=0 with one push of 0xFFFF → 20-cycle result, bit period 1 cycle, no hang.
